mem_stage: RTL



---
 rtl/mem_stage.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding Wishbone-style loads/stores and the MEM/WB register.
// Optional bus-ack watchdog is enabled by defining MEM_BUS_TIMEOUT_EN.
package mem_pkg;
  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10
  } mem_width_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    mem_width_t  mem_width;
    logic        mem_unsigned;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        valid;
  } mem_wb_reg_t;
endpackage

module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  ex_mem_reg_t ex_mem_reg,
  output mem_wb_reg_t mem_wb_reg,
  output logic        mem_stall,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  output logic        mem_misaligned_o,
  output logic        mem_misaligned_store_o,
  output logic [31:0] mem_bad_addr_o,
  output logic        mem_bus_err_o
);

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t      state, state_next;
  logic        flush_q;
  logic        timeout;
  logic [31:0] addr;
  logic        is_mem, access, misaligned;
  logic [3:0]  store_sel;
  logic [31:0] store_dat, load_data;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign addr       = ex_mem_reg.alu_result;
  assign is_mem     = ex_mem_reg.mem_read | ex_mem_reg.mem_write;
  assign access     = ex_mem_reg.valid & is_mem & ~flush;
  assign misaligned = ((ex_mem_reg.mem_width == W_HALF) & addr[0]) |
                      ((ex_mem_reg.mem_width == W_WORD) & (addr[1:0] != 2'b00));

  assign mem_misaligned_o       = (state == S_IDLE) & access & misaligned;
  assign mem_misaligned_store_o = mem_misaligned_o & ex_mem_reg.mem_write;
  assign mem_bad_addr_o         = mem_misaligned_o ? addr : 32'h0;

  assign lane_byte = bus_dat_i[{addr[1:0], 3'b000} +: 8];
  assign lane_half = addr[1] ? bus_dat_i[31:16] : bus_dat_i[15:0];

  // Store lane steering and load extraction share the same width decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    store_sel = 4'hF;
    store_dat = ex_mem_reg.rs2_data;
    load_data = bus_dat_i;
    case (ex_mem_reg.mem_width)
      W_BYTE: begin
        store_sel = 4'b0001 << addr[1:0];
        store_dat = {4{ex_mem_reg.rs2_data[7:0]}};
        load_data = {{24{~ex_mem_reg.mem_unsigned & lane_byte[7]}}, lane_byte};
      end
      W_HALF: begin
        store_sel = addr[1] ? 4'b1100 : 4'b0011;
        store_dat = {2{ex_mem_reg.rs2_data[15:0]}};
        load_data = {{16{~ex_mem_reg.mem_unsigned & lane_half[15]}}, lane_half};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    case (state)
      S_IDLE: begin
        if (access && !misaligned) begin
          mem_stall  = 1'b1;
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (bus_ack_i || timeout) state_next = S_IDLE;
        else                      mem_stall  = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      flush_q    <= 1'b0;
      bus_cyc_o  <= 1'b0;
      bus_stb_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_adr_o  <= 32'h0;
      bus_sel_o  <= 4'h0;
      bus_dat_o  <= 32'h0;
      mem_wb_reg <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= state_next;
      mem_wb_reg <= '0;
      case (state)
        S_IDLE: begin
          flush_q <= 1'b0;
          if (access && !misaligned) begin
            bus_cyc_o <= 1'b1;
            bus_stb_o <= 1'b1;
            bus_we_o  <= ex_mem_reg.mem_write;
            bus_adr_o <= {addr[31:2], 2'b00};
            bus_sel_o <= ex_mem_reg.mem_write ? store_sel : 4'h0;
            bus_dat_o <= store_dat;
          end else if (ex_mem_reg.valid && !flush && !is_mem) begin
            mem_wb_reg <= '{wb_data: addr, rd: ex_mem_reg.rd,
                            reg_write: ex_mem_reg.reg_write, valid: 1'b1};
          end
        end
        S_ACCESS: begin
          if (flush) flush_q <= 1'b1;
          if (bus_ack_i || timeout) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_sel_o <= 4'h0;
          end
          // A flush seen at any point during the access turns the completion into a bubble.
          if (bus_ack_i && !flush_q && !flush) begin
            mem_wb_reg <= '{wb_data: ex_mem_reg.mem_read ? load_data : addr,
                            rd: ex_mem_reg.rd, reg_write: ex_mem_reg.reg_write,
                            valid: 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_BUS_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             bus_err_q;

  assign timeout       = (state == S_ACCESS) & ~bus_ack_i &
                         (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_bus_err_o = bus_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      if (state != S_ACCESS)  cnt <= '0;
      else if (!bus_ack_i)    cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign timeout       = 1'b0;
  assign mem_bus_err_o = 1'b0;
`endif

endmodule
